// File: rtl/pong_match_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Pong match controller:
//   - pong_state_e : 2-bit match state encoding driven onto state_o
//   - WINNER_*     : encodings of the winner output
//   - DEF_*        : default match constants used as parameter defaults
// ----------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SERVE    = 2'b01,
    ST_PLAY     = 2'b10,
    ST_GAMEOVER = 2'b11
  } pong_state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P0   = 2'b01;
  localparam logic [1:0] WINNER_P1   = 2'b10;

  localparam int unsigned DEF_WIN_SCORE = 32'd9;
  localparam int unsigned DEF_HEIGHT    = 32'd320;

endpackage

// File: rtl/pong_match_ctrl_btn_sync.sv
// ----------------------------------------------------------------------------
// pong_btn_sync
// Brings the raw active-low start button into the clock domain and turns
// each press (falling edge) into a single-cycle pulse.
//   clock    in  system clock
//   reset    in  asynchronous, active-high; all stages reset to released (1)
//   btn_n_i  in  raw push-button, active-low, asynchronous
//   press_o  out one-cycle pulse per falling edge of the synchronised button
// A fall of btn_n_i ahead of edge 1 reaches sync2_q on edge 2, so press_o is
// high between edges 2 and 3 and the consumer acts on edge 3.
// ----------------------------------------------------------------------------
module pong_btn_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-stage synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Falling edge: was released last cycle, pressed now.
  assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// ----------------------------------------------------------------------------
// pong_match_ctrl
// Match sequencer for Pong: IDLE -> SERVE -> PLAY -> (SERVE | GAMEOVER) -> IDLE.
// Scores goals on the rising edge of the ball reaching a goal row, pauses the
// ball before each rally and ignores the start button for a hold-off period
// after entering IDLE or GAMEOVER.
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous, active-high
//   start_n   in   raw start button, active-low, asynchronous
//   ball_y    in   ball row (Y_W bits), synchronous to clock
//   running   out  ball engine may move the ball (PLAY only)
//   ball_rst  out  hold ball at centre (SERVE only)
//   score0    out  player 0 score (bottom goal), saturating
//   score1    out  player 1 score (top goal), saturating
//   point_p0  out  one-cycle pulse when player 0 scores
//   point_p1  out  one-cycle pulse when player 1 scores
//   winner    out  WINNER_NONE / WINNER_P0 / WINNER_P1, held in GAMEOVER
//   state_o   out  current pong_state_e encoding
// Build option: define PONG_WIN_BY_TWO_EN to require a two-point lead at or
// above WIN_SCORE (a saturated score always wins). Without it a player wins
// on reaching exactly WIN_SCORE.
// All outputs are registered.
// ----------------------------------------------------------------------------
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
  parameter int unsigned SCORE_W     = 32'd4,
  parameter int unsigned Y_W         = 32'd9,
  parameter int unsigned HEIGHT      = DEF_HEIGHT,
  parameter int unsigned HOLDOFF_CYC = 32'd50_000_000,
  parameter int unsigned SERVE_CYC   = 32'd25_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_n,
  input  logic [Y_W-1:0]     ball_y,
  output logic               running,
  output logic               ball_rst,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               point_p0,
  output logic               point_p1,
  output logic [1:0]         winner,
  output logic [1:0]         state_o
);

  // Score increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v == {SCORE_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + SCORE_W'(1);
    end
  endfunction

`ifdef PONG_WIN_BY_TWO_EN
  // Win when at/above WIN_SCORE with a lead of two, or when saturated.
  function automatic logic win_by_two(input logic [SCORE_W-1:0] mine,
                                      input logic [SCORE_W-1:0] other);
    win_by_two = (mine == {SCORE_W{1'b1}}) ||
                 ((mine >= SCORE_W'(WIN_SCORE)) && (mine > other) &&
                  ((mine - other) >= SCORE_W'(2)));
  endfunction
`endif

  pong_state_e        state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [SCORE_W-1:0] score0_q, score0_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [1:0]         winner_q, winner_d;
  logic               point_p0_q, point_p0_d;
  logic               point_p1_q, point_p1_d;
  logic               running_q, running_d;
  logic               ball_rst_q, ball_rst_d;
  logic               goal_top_q, goal_bot_q;

  logic               press_s;
  logic               goal_top_s, goal_bot_s;
  logic               rise_top_s, rise_bot_s;
  logic               hold_done_s;
  logic [SCORE_W-1:0] score0_inc_s, score1_inc_s;
  logic               win0_s, win1_s;

  pong_btn_sync u_btn_sync (
    .clock   (clock),
    .reset   (reset),
    .btn_n_i (start_n),
    .press_o (press_s)
  );

  assign goal_top_s  = (ball_y == Y_W'(1));
  assign goal_bot_s  = (ball_y == Y_W'(HEIGHT - 32'd1));
  // A ball parked on a goal row produces only one rising edge.
  assign rise_top_s  = goal_top_s & ~goal_top_q;
  assign rise_bot_s  = goal_bot_s & ~goal_bot_q;
  assign hold_done_s = (cnt_q >= 32'(HOLDOFF_CYC));

  assign score0_inc_s = sat_inc(score0_q);
  assign score1_inc_s = sat_inc(score1_q);

  // Win test on the score as it will be after this point.
  always_comb begin
    win0_s = 1'b0;
    win1_s = 1'b0;
`ifdef PONG_WIN_BY_TWO_EN
    win0_s = win_by_two(score0_inc_s, score1_q);
    win1_s = win_by_two(score1_inc_s, score0_q);
`else
    win0_s = (score0_inc_s == SCORE_W'(WIN_SCORE));
    win1_s = (score1_inc_s == SCORE_W'(WIN_SCORE));
`endif
  end

  // State, delay counter, scores and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      score0_q   <= {SCORE_W{1'b0}};
      score1_q   <= {SCORE_W{1'b0}};
      winner_q   <= WINNER_NONE;
      point_p0_q <= 1'b0;
      point_p1_q <= 1'b0;
      running_q  <= 1'b0;
      ball_rst_q <= 1'b0;
      goal_top_q <= 1'b0;
      goal_bot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
      winner_q   <= winner_d;
      point_p0_q <= point_p0_d;
      point_p1_q <= point_p1_d;
      running_q  <= running_d;
      ball_rst_q <= ball_rst_d;
      goal_top_q <= goal_top_s;
      goal_bot_q <= goal_bot_s;
    end
  end

  // Next-state, counter and score logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    winner_d   = winner_q;
    point_p0_d = 1'b0;
    point_p1_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        score0_d = {SCORE_W{1'b0}};
        score1_d = {SCORE_W{1'b0}};
        winner_d = WINNER_NONE;
        if (!hold_done_s) begin
          cnt_d = cnt_q + 32'd1;
        end else if (press_s) begin
          state_d = ST_SERVE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_SERVE: begin
        if (cnt_q >= 32'(SERVE_CYC - 32'd1)) begin
          state_d = ST_PLAY;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_PLAY: begin
        cnt_d = 32'd0;
        // Simultaneous goals cancel; only a single edge scores.
        if (rise_bot_s && !rise_top_s) begin
          score0_d   = score0_inc_s;
          point_p0_d = 1'b1;
          if (win0_s) begin
            state_d  = ST_GAMEOVER;
            winner_d = WINNER_P0;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (rise_top_s && !rise_bot_s) begin
          score1_d   = score1_inc_s;
          point_p1_d = 1'b1;
          if (win1_s) begin
            state_d  = ST_GAMEOVER;
            winner_d = WINNER_P1;
          end else begin
            state_d = ST_SERVE;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end

      ST_GAMEOVER: begin
        if (!hold_done_s) begin
          cnt_d = cnt_q + 32'd1;
        end else if (press_s) begin
          state_d  = ST_IDLE;
          cnt_d    = 32'd0;
          score0_d = {SCORE_W{1'b0}};
          score1_d = {SCORE_W{1'b0}};
          winner_d = WINNER_NONE;
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    // Engine controls follow the state being entered so they line up with state_o.
    running_d  = (state_d == ST_PLAY);
    ball_rst_d = (state_d == ST_SERVE);
  end

  assign running  = running_q;
  assign ball_rst = ball_rst_q;
  assign score0   = score0_q;
  assign score1   = score1_q;
  assign point_p0 = point_p0_q;
  assign point_p1 = point_p1_q;
  assign winner   = winner_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pong_match_ctrl
// Directed self-checking bench for pong_match_ctrl with small timing
// parameters (HOLDOFF_CYC=4, SERVE_CYC=3, WIN_SCORE=3, HEIGHT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_pong_match_ctrl;

  logic       clock;
  logic       reset;
  logic       start_n;
  logic [8:0] ball_y;
  logic       running;
  logic       ball_rst;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       point_p0;
  logic       point_p1;
  logic [1:0] winner;
  logic [1:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  localparam logic [8:0] Y_MID = 9'd8;
  localparam logic [8:0] Y_BOT = 9'd15;
  localparam logic [8:0] Y_TOP = 9'd1;

  pong_match_ctrl #(
    .WIN_SCORE   (32'd3),
    .SCORE_W     (32'd4),
    .Y_W         (32'd9),
    .HEIGHT      (32'd16),
    .HOLDOFF_CYC (32'd4),
    .SERVE_CYC   (32'd3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start_n  (start_n),
    .ball_y   (ball_y),
    .running  (running),
    .ball_rst (ball_rst),
    .score0   (score0),
    .score1   (score1),
    .point_p0 (point_p0),
    .point_p1 (point_p1),
    .winner   (winner),
    .state_o  (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance n rising edges, ending on a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Start the rally from SERVE-entry: checks SERVE for 3 cycles then PLAY.
  task automatic press_start();
    start_n = 1'b0;
    cyc(2);
    chk("pre_press_state", 32'(state_o), 32'd0);
    cyc(1);
    chk("press_state", 32'(state_o), 32'd1);
    start_n = 1'b1;
    cyc(3);
    chk("serve_to_play", 32'(state_o), 32'd2);
  endtask

  // One goal from PLAY; bot=1 means player 0 scores.
  task automatic score_pt(input bit bot, input int e0, input int e1, input int est);
    ball_y = bot ? Y_BOT : Y_TOP;
    cyc(1);
    chk("pt_score0", 32'(score0), 32'(e0));
    chk("pt_score1", 32'(score1), 32'(e1));
    chk("pt_state", 32'(state_o), 32'(est));
    chk("pt_pulse_p0", 32'(point_p0), 32'(bot));
    chk("pt_pulse_p1", 32'(point_p1), 32'(!bot));
    ball_y = Y_MID;
    if (est == 1) begin
      cyc(3);
      chk("pt_back_play", 32'(state_o), 32'd2);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start_n = 1'b1;
    ball_y  = Y_MID;
    cyc(2);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_ball_rst", 32'(ball_rst), 32'd0);
    chk("rst_score0", 32'(score0), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_pulses", 32'({point_p0, point_p1}), 32'd0);
    reset = 1'b0;

    // Early press inside hold-off is ignored.
    cyc(1);
    start_n = 1'b0;
    cyc(4);
    chk("early_press_ignored", 32'(state_o), 32'd0);
    start_n = 1'b1;
    cyc(3);
    chk("still_idle", 32'(state_o), 32'd0);

    // Press after hold-off; SERVE lasts exactly three cycles.
    start_n = 1'b0;
    cyc(2);
    chk("press_latency", 32'(state_o), 32'd0);
    cyc(1);
    chk("serve_state", 32'(state_o), 32'd1);
    chk("serve_ball_rst", 32'(ball_rst), 32'd1);
    chk("serve_running", 32'(running), 32'd0);
    cyc(2);
    chk("serve_hold", 32'(ball_rst), 32'd1);
    cyc(1);
    chk("play_state", 32'(state_o), 32'd2);
    chk("play_running", 32'(running), 32'd1);
    chk("play_ball_rst", 32'(ball_rst), 32'd0);
    start_n = 1'b1;

    // Ball parked on bottom goal row scores exactly once.
    ball_y = Y_BOT;
    cyc(1);
    chk("bot_score0", 32'(score0), 32'd1);
    chk("bot_pulse", 32'(point_p0), 32'd1);
    chk("bot_to_serve", 32'(state_o), 32'd1);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      pulses += int'(point_p0);
    end
    chk("parked_pulses", 32'(pulses), 32'd0);
    chk("parked_score0", 32'(score0), 32'd1);
    chk("parked_play", 32'(state_o), 32'd2);
    ball_y = Y_MID;
    cyc(1);

    score_pt(1'b0, 1, 1, 1);
    score_pt(1'b1, 2, 1, 1);

    // Asynchronous reset mid-PLAY at 2-1.
    #1 reset = 1'b1;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_score0", 32'(score0), 32'd0);
    chk("arst_score1", 32'(score1), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_pulses", 32'({point_p0, point_p1}), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(6);
    press_start();

`ifdef PONG_WIN_BY_TWO_EN
    score_pt(1'b1, 1, 0, 1);
    score_pt(1'b0, 1, 1, 1);
    score_pt(1'b1, 2, 1, 1);
    score_pt(1'b0, 2, 2, 1);
    score_pt(1'b1, 3, 2, 1);
    score_pt(1'b0, 3, 3, 1);
    score_pt(1'b1, 4, 3, 1);
    score_pt(1'b1, 5, 3, 3);
    chk("go_winner", 32'(winner), 32'd1);
`else
    score_pt(1'b1, 1, 0, 1);
    score_pt(1'b0, 1, 1, 1);
    score_pt(1'b1, 2, 1, 1);
    score_pt(1'b1, 3, 1, 3);
    chk("go_winner", 32'(winner), 32'd1);
`endif
    chk("go_running", 32'(running), 32'd0);
    chk("go_ball_rst", 32'(ball_rst), 32'd0);

    // Scores frozen in GAMEOVER.
    ball_y = Y_BOT;
    cyc(2);
    chk("go_frozen_pulse", 32'(point_p0), 32'd0);
`ifdef PONG_WIN_BY_TWO_EN
    chk("go_frozen_score0", 32'(score0), 32'd5);
`else
    chk("go_frozen_score0", 32'(score0), 32'd3);
`endif
    chk("go_hold_state", 32'(state_o), 32'd3);
    ball_y = Y_MID;
    cyc(4);

    // Press after hold-off returns to IDLE with cleared scoreboard.
    start_n = 1'b0;
    cyc(3);
    chk("go_to_idle", 32'(state_o), 32'd0);
    chk("idle_score0", 32'(score0), 32'd0);
    chk("idle_winner", 32'(winner), 32'd0);
    start_n = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
